remus_pdi_gearbox: RTL
======================

Name: remus_pdi_gearbox

Overview:
- Parametrised input-side width converter and elastic buffer for the Remus core.
- Accepts the external public-data stream at EXT_WIDTH bits per beat and packs it into CORE_WIDTH-bit words for the mode controller.
- Buffers up to DEPTH packed words and marks each word's valid bytes and segment end.
- Successor to the fixed 32-bit pdi path: it supports 8/16/32-bit external buses in front of a 32-bit (or wider) core, adds back-pressure buffering, and handles partial final words.

Parameters:
- EXT_WIDTH, 8, external bus width in bits. Allowed values: 8, 16, 32, 64.
- CORE_WIDTH, 32, core word width in bits. Must be a multiple of EXT_WIDTH, with R = CORE_WIDTH/EXT_WIDTH a power of two.
- DEPTH, 4, number of FIFO entries (CORE_WIDTH words). Must be ≥ 2 and a power of two.
- CW, $clog2(DEPTH+1), width of the fill-count output (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pdi_data  in  EXT_WIDTH  external data beat.
- pdi_valid  in  1  beat valid.
- pdi_last  in  1  beat is the final beat of a segment (AD or message).
- pdi_ready  out  1  beat accepted when pdi_valid & pdi_ready.
- core_data  out  CORE_WIDTH  packed word; first beat in the MSBs.
- core_bvalid  out  CORE_WIDTH/8  per-byte valid, MSB = byte 0.
- core_last  out  1  word closes a segment.
- core_valid  out  1  FIFO head valid.
- core_ready  in  1  core consumes head when core_valid & core_ready.
- fill  out  CW  number of occupied FIFO entries.

Behaviour:
- Reset, while rst=0, asynchronous:
  - pack counter = 0, pack register = 0, FIFO read/write pointers = 0.
  - Outputs: fill=0, core_valid=0, core_data=0, core_bvalid=0, core_last=0, pdi_ready=0.
  - pdi_ready rises in the first cycle after rst deasserts.
  - Reset mid-segment discards all partial and buffered data. No word is emitted afterwards for the discarded beats.
- Packing:
  - On each accepted beat, write the beat into slot pack_cnt. Slot 0 is the most-significant EXT_WIDTH bits.
  - pack_cnt increments modulo R.
  - A word is complete when pack_cnt == R-1 or pdi_last=1 on the accepted beat.
- Completion:
  - In the same edge, push {word, bvalid, last} into the FIFO and clear the pack register and pack_cnt to 0.
  - Unfilled slots are zero-padded.
  - bvalid has ones for bytes 0 .. ((pack_cnt+1)*EXT_WIDTH/8 - 1).
  - last = pdi_last.
- Passthrough: when R=1, every accepted beat is a complete word with bvalid all-ones.
- pdi_ready:
  - pdi_ready = (fill != DEPTH), taken from registered state only.
  - A pop in the same cycle does not raise pdi_ready; there is no combinational path from core_ready to pdi_ready.
  - Non-completing beats are also gated by pdi_ready, so the pack register never holds a word the FIFO cannot take.
- Output side:
  - First-word-fall-through: core_data, core_bvalid and core_last always show the FIFO head.
  - core_valid = (fill != 0).
  - Latency: a word becomes visible on core_* exactly 1 cycle after the edge that accepts its completing beat.
- Simultaneous push and pop:
  - fill unchanged; both pointers advance.
  - When fill==DEPTH, push cannot occur (pdi_ready=0); a pop alone decrements fill.
  - When fill==0, a pop cannot occur.
- Pointers wrap modulo DEPTH.
- fill is always in 0..DEPTH. Overflow or underflow is impossible by construction; assertions check this.
- pdi_last with pack_cnt==0 and R>1 yields a word with only byte-group 0 valid.
- pdi_data is ignored when pdi_valid=0 or pdi_ready=0.
- Holding core_ready=1 with core_valid=0 has no effect.

Decomposition:
- Shared package/header (alongside params.vh): allowed EXT_WIDTH values, the R/bvalid-width derivation macros, and the slot-ordering constant (MSB-first).
- One sub-module is natural: remus_sync_fifo (DATA_W, DEPTH), first-word-fall-through, with push, pop, full, empty and fill, plus async active-low reset.
- Packing logic stays in remus_pdi_gearbox.

Test Plan:
- Full word, EXT_WIDTH=8: beats 0x11,0x22,0x33,0x44 with last on 0x44 → next cycle core_data=0x11223344, core_bvalid=4'b1111, core_last=1, fill=1.
- Partial word: beats 0xAA,0xBB with last on 0xBB → core_data=0xAABB0000, core_bvalid=4'b1100, core_last=1.
- Back-pressure: core_ready=0, stream 16 beats (EXT_WIDTH=8, DEPTH=4) → fill reaches 4, then pdi_ready=0. Release core_ready → words pop in order 0x00010203, 0x04050607, …; pdi_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at fill=2 with a completing beat and core_ready=1 → fill stays 2 and the pointer wrap at DEPTH is exercised over 3 rounds.
- Reset mid-word: accept 0x11,0x22 then pulse rst low → fill=0 and core_valid=0. New beats 0x55,0x66,0x77,0x88 → core_data=0x55667788, with no residue of 0x11/0x22.
- Passthrough, EXT_WIDTH=32: beat 0xDEADBEEF with last → core_data=0xDEADBEEF, core_bvalid=4'b1111, 1-cycle latency.

Source files
------------

// File: rtl/remus_pdi_gearbox_pkg.sv
// Shared constants and helpers for the Remus public-data input gearbox.
// Covers legal bus widths, the pack ratio and byte-lane counts, and the MSB-first slot order.
package remus_pdi_gearbox_pkg;

  localparam bit SLOT_MSB_FIRST = 1'b1;

  function automatic bit ext_width_ok(int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic int pack_ratio(int core_w, int ext_w);
    return core_w / ext_w;
  endfunction

  function automatic int byte_lanes(int w);
    return w / 8;
  endfunction

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Slot 0 lands in the most-significant bits of the packed word
  function automatic int slot_lsb(int slot, int ext_w, int core_w);
    return SLOT_MSB_FIRST ? core_w - ext_w * (slot + 1) : ext_w * slot;
  endfunction

endpackage

// File: rtl/remus_pdi_gearbox_fifo.sv
// First-word-fall-through synchronous FIFO with a registered fill count.
// The head reads as zero while empty, so outputs are clean after reset.
module remus_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     fill
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign fill    = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

  a_fill_range: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/remus_pdi_gearbox.sv
// Packs EXT_WIDTH-bit public-data beats into CORE_WIDTH-bit words, tagging byte
// validity and segment end, and buffers them for the mode controller.
module remus_pdi_gearbox
  import remus_pdi_gearbox_pkg::*;
#(
  parameter int EXT_WIDTH  = 8,
  parameter int CORE_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXT_WIDTH-1:0]    pdi_data,
  input  logic                    pdi_valid,
  input  logic                    pdi_last,
  output logic                    pdi_ready,
  output logic [CORE_WIDTH-1:0]   core_data,
  output logic [CORE_WIDTH/8-1:0] core_bvalid,
  output logic                    core_last,
  output logic                    core_valid,
  input  logic                    core_ready,
  output logic [CW-1:0]           fill
);

  localparam int R      = pack_ratio(CORE_WIDTH, EXT_WIDTH);
  localparam int BW     = byte_lanes(CORE_WIDTH);
  localparam int PCW    = (R > 1) ? $clog2(R) : 1;
  localparam int DATA_W = CORE_WIDTH + BW + 1;

  logic [CORE_WIDTH-1:0] pack_reg;
  logic [PCW-1:0]        pack_cnt;
  logic                  ready_en;
  logic                  accept;
  logic                  complete;
  logic [CORE_WIDTH-1:0] word;
  logic [BW-1:0]         bvalid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     head;

  // ready_en keeps pdi_ready low through reset and the edge that releases it
  assign pdi_ready = ready_en & ~fifo_full;
  assign accept    = pdi_valid & pdi_ready;
  assign complete  = accept & ((pack_cnt == PCW'(R - 1)) | pdi_last);

  always_comb begin
    word = pack_reg;
    for (int i = 0; i < R; i++) begin
      if (pack_cnt == PCW'(i))
        word[slot_lsb(i, EXT_WIDTH, CORE_WIDTH) +: EXT_WIDTH] = pdi_data;
    end
  end

  always_comb begin
    bvalid = '0;
    for (int b = 0; b < BW; b++) begin
      if (b < (int'(pack_cnt) + 1) * (EXT_WIDTH / 8))
        bvalid[BW-1-b] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_reg <= '0;
      pack_cnt <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (complete) begin
        pack_reg <= '0;
        pack_cnt <= '0;
      end else if (accept) begin
        pack_reg <= word;
        pack_cnt <= pack_cnt + PCW'(1);
      end
    end
  end

  remus_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (complete),
    .push_data ({word, bvalid, pdi_last}),
    .pop       (core_valid & core_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign core_valid  = ~fifo_empty;
  assign core_data   = head[DATA_W-1 -: CORE_WIDTH];
  assign core_bvalid = head[BW:1];
  assign core_last   = head[0];

  a_ext_width: assert property (@(posedge clk) ext_width_ok(EXT_WIDTH));
  a_ratio: assert property (@(posedge clk)
    (CORE_WIDTH % EXT_WIDTH == 0) && is_pow2(R) && is_pow2(DEPTH) && (DEPTH >= 2));

endmodule
